// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: decodes instructions, holds A/D/pc, drives the
// external 16-bit alu and commits its result, stalling in WAIT on a slow data memory.
module hack_cpu_ctrl #(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       in_m,
    input  logic              mem_ready,
    input  logic [15:0]       alu_o,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic              zx,
    output logic              nx,
    output logic              zy,
    output logic              ny,
    output logic              f,
    output logic              no,
    output logic [15:0]       out_m,
    output logic              write_m,
    output logic [ADDR_W-1:0] address_m,
    output logic [ADDR_W-1:0] pc,
    output logic              retired,
    output logic              state_dbg
);

    // Handshake: an instruction transfers on a clock edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in RUN, and while in WAIT
    // the held copy in ir is executed and instr/instr_valid are ignored.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    logic [15:0]       ir;
    logic [15:0]       a_reg;
    logic [15:0]       d_reg;

    logic [15:0]       cur;
    logic              is_c;
    logic              a_bit;
    logic              d1, d2, d3;
    logic              j1, j2, j3;
    logic              need_mem;
    logic              accept;
    logic              commit;
    logic              stall;
    logic              jump;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_bits;

    // Decode always works on the held instruction while waiting on memory.
    assign cur      = (state == ST_WAIT) ? ir : instr;
    assign is_c     = cur[15];
    assign a_bit    = is_c & cur[12];
    assign d1       = is_c & cur[5];
    assign d2       = is_c & cur[4];
    assign d3       = is_c & cur[3];
    assign j1       = is_c & cur[2];
    assign j2       = is_c & cur[1];
    assign j3       = is_c & cur[0];
    assign need_mem = is_c & (cur[12] | cur[3]);

    assign unused_bits = ^cur[14:13];

    assign accept = (state == ST_RUN) & instr_valid;
    assign commit = (state == ST_WAIT) ? mem_ready
                                       : (accept & (~need_mem | mem_ready));
    assign stall  = accept & need_mem & ~mem_ready;

    assign jump   = (j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_zr & ~alu_ng);
    assign pc_inc = pc + PC_ONE;

    assign alu_x = d_reg;
    assign alu_y = a_bit ? in_m : a_reg;
    assign {zx, nx, zy, ny, f, no} = is_c ? cur[11:6] : 6'b0;

    assign out_m       = alu_o;
    assign write_m     = commit & d3;
    assign retired     = commit;
    assign address_m   = a_reg[ADDR_W-1:0];
    assign instr_ready = (state == ST_RUN);
    assign state_dbg   = state;

    // All commit updates use pre-edge values, so a jump reads the old A even
    // when the same instruction also writes A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            ir    <= '0;
            a_reg <= '0;
            d_reg <= '0;
            pc    <= PC_RESET;
        end else begin
            if (stall) begin
                ir    <= instr;
                state <= ST_WAIT;
            end
            if (commit) begin
                state <= ST_RUN;
                if (!is_c) begin
                    a_reg <= cur;
                    pc    <= pc_inc;
                end else begin
                    if (d1) a_reg <= alu_o;
                    if (d2) d_reg <= alu_o;
                    pc <= jump ? a_reg[ADDR_W-1:0] : pc_inc;
                end
            end
        end
    end

endmodule
